// File: rtl/button_debounce.sv
// ---------------------------------------------------------------------------
// button_debounce
//
// Conditioning stage for the board push-buttons. Each raw pin is brought into
// the clk domain through a two-flop synchroniser, optionally inverted so that
// a 1 always means "pressed", and then filtered by a small per-button state
// machine. A change is accepted only after the synchronised input has held
// the new value for DEBOUNCE_CYCLES consecutive cycles. The block produces a
// clean level and one-cycle press, release and long-hold event pulses.
//
// Ports
//   clk          rising-edge system clock (100 MHz on the board)
//   rst          synchronous reset, active-high; overrides every event
//   but_raw      raw, asynchronous button pins, one bit per channel
//   btn_level    debounced pressed level (1 = pressed)
//   btn_press    one-cycle pulse when a press is accepted
//   btn_release  one-cycle pulse when a release is accepted
//   btn_hold     one-cycle pulse, once per press, after HOLD_CYCLES pressed
//
// Parameters
//   NUM_BUTTONS      number of independent channels
//   DEBOUNCE_CYCLES  stable cycles needed to accept a change (>= 2)
//   HOLD_CYCLES      cycles in PRESSED before btn_hold fires (>= 1)
//   ACTIVE_LOW       1: a low pin level means pressed
//   CNT_W            counter width, must hold max(DEBOUNCE, HOLD) - 1
// ---------------------------------------------------------------------------
module button_debounce #(
   parameter int NUM_BUTTONS     = 2,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int HOLD_CYCLES     = 50_000_000,
   parameter bit ACTIVE_LOW      = 1'b0,
   parameter int CNT_W           = 26
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_BUTTONS-1:0] but_raw,
   output logic [NUM_BUTTONS-1:0] btn_level,
   output logic [NUM_BUTTONS-1:0] btn_press,
   output logic [NUM_BUTTONS-1:0] btn_release,
   output logic [NUM_BUTTONS-1:0] btn_hold
);

   typedef enum logic [1:0] {
      ST_RELEASED     = 2'd0,
      ST_PRESS_WAIT   = 2'd1,
      ST_PRESSED      = 2'd2,
      ST_RELEASE_WAIT = 2'd3
   } state_t;

   // Terminal counts, sized to the counter so comparisons are width-exact.
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

   // The raw-pin level that means "not pressed"; the synchroniser resets to
   // it so that reset never looks like a press on an active-low board.
   localparam logic [NUM_BUTTONS-1:0] SYNC_IDLE = {NUM_BUTTONS{ACTIVE_LOW}};

   logic [NUM_BUTTONS-1:0] sync1_q, sync1_d;
   logic [NUM_BUTTONS-1:0] sync2_q, sync2_d;
   logic [NUM_BUTTONS-1:0] pressed;

   // Two-flop synchroniser: the first stage may go metastable, the second
   // gives it a full cycle to resolve before any logic looks at it.
   always_comb begin
      sync1_d = but_raw;
      sync2_d = sync1_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= SYNC_IDLE;
         sync2_q <= SYNC_IDLE;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   // Normalise polarity after synchronisation so the FSMs only ever see a
   // "pressed" flag.
   assign pressed = ACTIVE_LOW ? ~sync2_q : sync2_q;

   for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_chan

      state_t           state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             hold_done_q, hold_done_d;
      logic             level_q, level_d;
      logic             press_q, press_d;
      logic             release_q, release_d;
      logic             hold_q, hold_d;
      logic             s;

      assign s = pressed[g];

      // Next-state and event logic. A single counter serves both as the
      // debounce timer in the WAIT states and as the hold timer in PRESSED.
      // Event pulses are decoded from the transition being taken, so the
      // registered outputs line up with the state they describe.
      always_comb begin
         state_d     = state_q;
         cnt_d       = cnt_q;
         hold_done_d = hold_done_q;
         press_d     = 1'b0;
         release_d   = 1'b0;
         hold_d      = 1'b0;

         case (state_q)
            ST_RELEASED: begin
               if (s) begin
                  state_d = ST_PRESS_WAIT;
                  cnt_d   = '0;
               end
            end

            ST_PRESS_WAIT: begin
               if (!s) begin
                  state_d = ST_RELEASED;
                  cnt_d   = '0;
               end else if (cnt_q == DEB_LAST) begin
                  state_d     = ST_PRESSED;
                  cnt_d       = '0;
                  press_d     = 1'b1;
                  hold_done_d = 1'b0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end

            ST_PRESSED: begin
               if (!s) begin
                  state_d = ST_RELEASE_WAIT;
                  cnt_d   = '0;
               end else if (cnt_q != HOLD_LAST) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end

            ST_RELEASE_WAIT: begin
               if (s) begin
                  // Release bounce: back to PRESSED silently, hold timing
                  // starts over.
                  state_d = ST_PRESSED;
                  cnt_d   = '0;
               end else if (cnt_q == DEB_LAST) begin
                  state_d   = ST_RELEASED;
                  cnt_d     = '0;
                  release_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end

            default: begin
               state_d = ST_RELEASED;
               cnt_d   = '0;
            end
         endcase

         // The hold pulse fires on the cycle the PRESSED count lands on its
         // terminal value. The done flag keeps it to one pulse per accepted
         // press, even when a release bounce restarts the count; it also
         // covers HOLD_CYCLES == 1, where the terminal value is hit on entry.
         if (state_d == ST_PRESSED && cnt_d == HOLD_LAST && !hold_done_d) begin
            hold_d      = 1'b1;
            hold_done_d = 1'b1;
         end

         level_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_WAIT);
      end

      // State, counter and registered outputs. Reset drops every output
      // without generating a release pulse.
      always_ff @(posedge clk) begin
         if (rst) begin
            state_q     <= ST_RELEASED;
            cnt_q       <= '0;
            hold_done_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            hold_q      <= 1'b0;
         end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_done_q <= hold_done_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            hold_q      <= hold_d;
         end
      end

      assign btn_level[g]   = level_q;
      assign btn_press[g]   = press_q;
      assign btn_release[g] = release_q;
      assign btn_hold[g]    = hold_q;
   end

endmodule

// File: tb/tb_button_debounce.sv
// ---------------------------------------------------------------------------
// tb_button_debounce
//
// Directed bench for button_debounce with DEBOUNCE_CYCLES=4, HOLD_CYCLES=10.
// Two instances run side by side: an active-high build driven by raw and an
// active-low build driven by ~raw, so both must produce identical outputs.
// Inputs are changed 1 time unit after a rising edge; the next rising edge
// is the first edge that samples the new pin value. Outputs are sampled at
// the same point, so "tick i" below means "just after the i-th edge after
// the pin change". A press is then expected at tick DEBOUNCE_CYCLES+3 = 7.
// ---------------------------------------------------------------------------
module tb_button_debounce;

   localparam int DEB  = 4;
   localparam int HOLD = 10;
   localparam int LAT  = DEB + 3;

   logic       clk;
   logic       rst;
   logic [1:0] raw;
   logic [1:0] raw_al;

   logic [1:0] level, press, release_o, hold;
   logic [1:0] level_al, press_al, release_al, hold_al;

   int n_checks;
   int n_fail;

   assign raw_al = ~raw;

   button_debounce #(
      .NUM_BUTTONS(2), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD),
      .ACTIVE_LOW(1'b0), .CNT_W(26)
   ) dut (
      .clk(clk), .rst(rst), .but_raw(raw),
      .btn_level(level), .btn_press(press),
      .btn_release(release_o), .btn_hold(hold)
   );

   button_debounce #(
      .NUM_BUTTONS(2), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD),
      .ACTIVE_LOW(1'b1), .CNT_W(26)
   ) dut_al (
      .clk(clk), .rst(rst), .but_raw(raw_al),
      .btn_level(level_al), .btn_press(press_al),
      .btn_release(release_al), .btn_hold(hold_al)
   );

   // 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something stalls the sequence
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Reset state: every output of both builds low
   task automatic test_reset();
      rst = 1'b1;
      raw = 2'b00;
      idle(3);
      n_checks++;
      if ({level, press, release_o, hold} !== 8'h00) begin
         n_fail++;
         $display("[TB] FAIL reset_ah: outputs=%b expected %b", {level, press, release_o, hold}, 8'h00);
      end
      n_checks++;
      if ({level_al, press_al, release_al, hold_al} !== 8'h00) begin
         n_fail++;
         $display("[TB] FAIL reset_al: outputs=%b expected %b", {level_al, press_al, release_al, hold_al}, 8'h00);
      end
      rst = 1'b0;
      idle(2);
   endtask

   // Clean press and release on channel 0, checked cycle by cycle
   task automatic test_clean_press();
      logic [1:0] exp_press, exp_level, exp_rel;
      raw[0] = 1'b1;
      for (int i = 1; i <= LAT + 2; i++) begin
         tick();
         exp_press = (i == LAT) ? 2'b01 : 2'b00;
         exp_level = (i >= LAT) ? 2'b01 : 2'b00;
         n_checks++;
         if ({press, press_al} !== {exp_press, exp_press}) begin
            n_fail++;
            $display("[TB] FAIL clean_press tick %0d: press=%b al=%b expected %b", i, press, press_al, exp_press);
         end
         n_checks++;
         if ({level, level_al} !== {exp_level, exp_level}) begin
            n_fail++;
            $display("[TB] FAIL clean_level tick %0d: level=%b al=%b expected %b", i, level, level_al, exp_level);
         end
      end
      raw[0] = 1'b0;
      for (int i = 1; i <= LAT + 2; i++) begin
         tick();
         exp_rel   = (i == LAT) ? 2'b01 : 2'b00;
         exp_level = (i < LAT) ? 2'b01 : 2'b00;
         n_checks++;
         if ({release_o, release_al} !== {exp_rel, exp_rel}) begin
            n_fail++;
            $display("[TB] FAIL clean_release tick %0d: release=%b al=%b expected %b", i, release_o, release_al, exp_rel);
         end
         n_checks++;
         if ({level, level_al} !== {exp_level, exp_level}) begin
            n_fail++;
            $display("[TB] FAIL clean_release_level tick %0d: level=%b al=%b expected %b", i, level, level_al, exp_level);
         end
      end
      idle(4);
   endtask

   // Short pulse is rejected; short dips while pressed are ignored
   task automatic test_glitch();
      raw[0] = 1'b1;
      idle(3);
      raw[0] = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         n_checks++;
         if ({level, press, level_al, press_al} !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL glitch_press tick %0d: level=%b press=%b al=%b/%b expected 00/00", i, level, press, level_al, press_al);
         end
      end
      raw[0] = 1'b1;
      idle(LAT + 2);
      for (int i = 1; i <= 12; i++) begin
         raw[0] = (i == 1 || i == 6) ? 1'b0 : 1'b1;
         tick();
         n_checks++;
         if ({level, release_o, level_al, release_al} !== 8'b01_00_01_00) begin
            n_fail++;
            $display("[TB] FAIL glitch_dip tick %0d: level=%b release=%b al=%b/%b expected 01/00", i, level, release_o, level_al, release_al);
         end
      end
      raw[0] = 1'b0;
      idle(12);
   endtask

   // Long hold on channel 1: one press, one hold 9 cycles later, one release
   task automatic test_hold();
      int press_cnt, press_tick, hold_cnt, hold_tick, rel_cnt, rel_tick;
      int press_cnt_al, hold_cnt_al, hold_tick_al, rel_cnt_al;
      press_cnt = 0; press_tick = -1; hold_cnt = 0; hold_tick = -1;
      rel_cnt = 0; rel_tick = -1;
      press_cnt_al = 0; hold_cnt_al = 0; hold_tick_al = -1; rel_cnt_al = 0;
      raw[1] = 1'b1;
      for (int i = 1; i <= 30; i++) begin
         tick();
         if (press[1])    begin press_cnt++; press_tick = i; end
         if (hold[1])     begin hold_cnt++;  hold_tick  = i; end
         if (press_al[1]) press_cnt_al++;
         if (hold_al[1])  begin hold_cnt_al++; hold_tick_al = i; end
      end
      n_checks++;
      if (press_cnt != 1 || press_tick != LAT) begin
         n_fail++;
         $display("[TB] FAIL hold_press: count=%0d tick=%0d expected 1 at %0d", press_cnt, press_tick, LAT);
      end
      n_checks++;
      if (hold_cnt != 1 || hold_tick != LAT + HOLD - 1) begin
         n_fail++;
         $display("[TB] FAIL hold_pulse: count=%0d tick=%0d expected 1 at %0d", hold_cnt, hold_tick, LAT + HOLD - 1);
      end
      n_checks++;
      if (press_cnt_al != 1 || hold_cnt_al != 1 || hold_tick_al != LAT + HOLD - 1) begin
         n_fail++;
         $display("[TB] FAIL hold_al: press=%0d hold=%0d tick=%0d expected 1/1 at %0d", press_cnt_al, hold_cnt_al, hold_tick_al, LAT + HOLD - 1);
      end
      raw[1] = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (release_o[1])  begin rel_cnt++; rel_tick = i; end
         if (release_al[1]) rel_cnt_al++;
      end
      n_checks++;
      if (rel_cnt != 1 || rel_tick != LAT || rel_cnt_al != 1) begin
         n_fail++;
         $display("[TB] FAIL hold_release: count=%0d tick=%0d al_count=%0d expected 1 at %0d", rel_cnt, rel_tick, rel_cnt_al, LAT);
      end
      idle(4);
   endtask

   // Both channels pressed and released on the same edge
   task automatic test_back_to_back();
      raw = 2'b11;
      idle(LAT - 1);
      n_checks++;
      if ({press, press_al} !== 4'b0000) begin
         n_fail++;
         $display("[TB] FAIL simul_early: press=%b al=%b expected 00", press, press_al);
      end
      tick();
      n_checks++;
      if ({press, press_al} !== 4'b1111) begin
         n_fail++;
         $display("[TB] FAIL simul_press: press=%b al=%b expected 11", press, press_al);
      end
      raw = 2'b00;
      idle(LAT - 1);
      n_checks++;
      if ({release_o, release_al} !== 4'b0000 || {level, level_al} !== 4'b1111) begin
         n_fail++;
         $display("[TB] FAIL simul_early_rel: release=%b level=%b expected 00/11", release_o, level);
      end
      tick();
      n_checks++;
      if ({release_o, release_al} !== 4'b1111) begin
         n_fail++;
         $display("[TB] FAIL simul_release: release=%b al=%b expected 11", release_o, release_al);
      end
      idle(4);
   endtask

   // Reset while pressed: outputs drop silently, then a fresh debounce
   task automatic test_reset_mid_press();
      logic [1:0] exp_press;
      raw[0] = 1'b1;
      idle(LAT + 1);
      n_checks++;
      if ({level, level_al} !== 4'b0101) begin
         n_fail++;
         $display("[TB] FAIL rst_pre_level: level=%b al=%b expected 01", level, level_al);
      end
      rst = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         tick();
         n_checks++;
         if ({level, press, release_o, hold, level_al, press_al, release_al, hold_al} !== 16'h0000) begin
            n_fail++;
            $display("[TB] FAIL rst_outputs tick %0d: ah=%b al=%b expected all 0", i,
                     {level, press, release_o, hold}, {level_al, press_al, release_al, hold_al});
         end
      end
      rst = 1'b0;
      for (int i = 1; i <= LAT + 2; i++) begin
         tick();
         exp_press = (i == LAT) ? 2'b01 : 2'b00;
         n_checks++;
         if ({press, press_al} !== {exp_press, exp_press} || {release_o, release_al} !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL rst_repress tick %0d: press=%b release=%b al=%b/%b expected %b/00",
                     i, press, release_o, press_al, release_al, exp_press);
         end
      end
      raw[0] = 1'b0;
      idle(12);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      raw      = 2'b00;
      test_reset();
      test_clean_press();
      test_glitch();
      test_hold();
      test_back_to_back();
      test_reset_mid_press();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
